// File: rtl/rv32i_types.sv
// Shared integer-pipeline types: ALU opcodes and reservation-station entry layout.
// Tag fields are sized for the widest ROB tag; narrower tags are zero-extended.
package rv32i_types;

  typedef enum logic [2:0] {
    alu_add = 3'd0,
    alu_sll = 3'd1,
    alu_sra = 3'd2,
    alu_sub = 3'd3,
    alu_xor = 3'd4,
    alu_srl = 3'd5,
    alu_or  = 3'd6,
    alu_and = 3'd7
  } alu_ops;

  localparam int RS_TAG_MAX_W = 8;

  typedef struct packed {
    logic                    rdy;
    logic [31:0]             val;
    logic [RS_TAG_MAX_W-1:0] tag;
  } rs_src_t;

  typedef struct packed {
    logic                    busy;
    alu_ops                  aluop;
    logic [RS_TAG_MAX_W-1:0] dest_tag;
    rs_src_t                 src1;
    rs_src_t                 src2;
  } rs_entry_t;

  // A pending source captures the CDB value when the broadcast tag matches its producer.
  function automatic rs_src_t rs_wake(input rs_src_t src, input logic cdb_vld,
                                      input logic [RS_TAG_MAX_W-1:0] cdb_tag,
                                      input logic [31:0] cdb_data);
    rs_src_t res;
    res = src;
    if (cdb_vld && !src.rdy && (src.tag == cdb_tag)) begin
      res.rdy = 1'b1;
      res.val = cdb_data;
    end
    return res;
  endfunction

endpackage

// File: rtl/rs_prio_pick.sv
// Find-first-set: index of the lowest set bit of req, plus a found flag.
// Purely combinational; idx is 0 when nothing is set.
module rs_prio_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  output logic [$clog2(N)-1:0] idx,
  output logic                 found
);
  localparam int IDX_W = $clog2(N);

  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = IDX_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: holds dispatched ops, wakes pending operands from the CDB,
// and presents the lowest-index operand-complete op to the ALU; issue is combinational from state.
module alu_rs
  import rv32i_types::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             dispatch_valid,
  output logic             dispatch_ready,
  input  alu_ops           dispatch_aluop,
  input  logic [TAG_W-1:0] dispatch_dest_tag,
  input  logic             dispatch_src1_rdy,
  input  logic             dispatch_src2_rdy,
  input  logic [31:0]      dispatch_src1_val,
  input  logic [31:0]      dispatch_src2_val,
  input  logic [TAG_W-1:0] dispatch_src1_tag,
  input  logic [TAG_W-1:0] dispatch_src2_tag,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_data,
  output logic             issue_valid,
  input  logic             issue_ready,
  output alu_ops           issue_aluop,
  output logic [31:0]      issue_a,
  output logic [31:0]      issue_b,
  output logic [TAG_W-1:0] issue_tag
);
  localparam int IDX_W = $clog2(DEPTH);

  rs_entry_t rs_q [DEPTH];
  rs_entry_t rs_d [DEPTH];

  logic [DEPTH-1:0]        free_vec;
  logic [DEPTH-1:0]        cand_vec;
  logic [IDX_W-1:0]        free_idx;
  logic [IDX_W-1:0]        sel_idx;
  logic                    free_found;
  logic                    sel_found;
  logic                    issue_fire;
  logic                    disp_fire;
  logic [RS_TAG_MAX_W-1:0] cdb_tag_x;
  rs_src_t                 disp_src1;
  rs_src_t                 disp_src2;

  assign cdb_tag_x = RS_TAG_MAX_W'(cdb_tag);

  always_comb begin
    free_vec = '0;
    cand_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      free_vec[i] = ~rs_q[i].busy;
      cand_vec[i] = rs_q[i].busy & rs_q[i].src1.rdy & rs_q[i].src2.rdy;
    end
  end

  rs_prio_pick #(.N(DEPTH)) u_free_pick (.req(free_vec), .idx(free_idx), .found(free_found));
  rs_prio_pick #(.N(DEPTH)) u_sel_pick  (.req(cand_vec), .idx(sel_idx),  .found(sel_found));

  // Ready is from registered state only, so an issue in a full cycle does not open a slot.
  assign dispatch_ready = free_found;
  assign issue_valid    = sel_found;
  assign issue_fire     = sel_found & issue_ready;
  assign disp_fire      = dispatch_valid & free_found & ~flush;

  always_comb begin
    issue_aluop = alu_add;
    issue_a     = '0;
    issue_b     = '0;
    issue_tag   = '0;
    if (sel_found) begin
      issue_aluop = rs_q[sel_idx].aluop;
      issue_a     = rs_q[sel_idx].src1.val;
      issue_b     = rs_q[sel_idx].src2.val;
      issue_tag   = rs_q[sel_idx].dest_tag[TAG_W-1:0];
    end
  end

  // Incoming operands pass through the same wakeup as stored ones to cover the bypass case.
  always_comb begin
    disp_src1 = rs_wake('{rdy: dispatch_src1_rdy, val: dispatch_src1_val,
                          tag: RS_TAG_MAX_W'(dispatch_src1_tag)}, cdb_valid, cdb_tag_x, cdb_data);
    disp_src2 = rs_wake('{rdy: dispatch_src2_rdy, val: dispatch_src2_val,
                          tag: RS_TAG_MAX_W'(dispatch_src2_tag)}, cdb_valid, cdb_tag_x, cdb_data);
  end

  always_comb begin
    rs_d = rs_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (rs_q[i].busy) begin
        rs_d[i].src1 = rs_wake(rs_q[i].src1, cdb_valid, cdb_tag_x, cdb_data);
        rs_d[i].src2 = rs_wake(rs_q[i].src2, cdb_valid, cdb_tag_x, cdb_data);
      end
    end
    if (issue_fire) begin
      rs_d[sel_idx].busy = 1'b0;
    end
    if (disp_fire) begin
      rs_d[free_idx].busy     = 1'b1;
      rs_d[free_idx].aluop    = dispatch_aluop;
      rs_d[free_idx].dest_tag = RS_TAG_MAX_W'(dispatch_dest_tag);
      rs_d[free_idx].src1     = disp_src1;
      rs_d[free_idx].src2     = disp_src2;
    end
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        rs_d[i].busy = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        rs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        rs_q[i] <= rs_d[i];
      end
    end
  end

endmodule

// File: tb/tb_alu_rs.sv
// Randomised scoreboard bench for alu_rs against a slot-level behavioural model.
// The driver predicts each cycle's issued op; an independent monitor pops and compares on handshake.
module tb_alu_rs;
  import rv32i_types::*;

  localparam int DEPTH = 4;
  localparam int TAG_W = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic             dispatch_valid;
  logic             dispatch_ready;
  alu_ops           dispatch_aluop;
  logic [TAG_W-1:0] dispatch_dest_tag;
  logic             dispatch_src1_rdy, dispatch_src2_rdy;
  logic [31:0]      dispatch_src1_val, dispatch_src2_val;
  logic [TAG_W-1:0] dispatch_src1_tag, dispatch_src2_tag;
  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [31:0]      cdb_data;
  logic             issue_valid;
  logic             issue_ready;
  alu_ops           issue_aluop;
  logic [31:0]      issue_a, issue_b;
  logic [TAG_W-1:0] issue_tag;

  alu_rs #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
    .dispatch_aluop(dispatch_aluop), .dispatch_dest_tag(dispatch_dest_tag),
    .dispatch_src1_rdy(dispatch_src1_rdy), .dispatch_src2_rdy(dispatch_src2_rdy),
    .dispatch_src1_val(dispatch_src1_val), .dispatch_src2_val(dispatch_src2_val),
    .dispatch_src1_tag(dispatch_src1_tag), .dispatch_src2_tag(dispatch_src2_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_aluop(issue_aluop),
    .issue_a(issue_a), .issue_b(issue_b), .issue_tag(issue_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    alu_ops           op;
    logic [31:0]      a;
    logic [31:0]      b;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Behavioural model: one record per slot.
  bit               m_busy [DEPTH];
  alu_ops           m_op   [DEPTH];
  logic [TAG_W-1:0] m_tag  [DEPTH];
  bit               m_r1   [DEPTH];
  bit               m_r2   [DEPTH];
  logic [31:0]      m_v1   [DEPTH];
  logic [31:0]      m_v2   [DEPTH];
  logic [TAG_W-1:0] m_t1   [DEPTH];
  logic [TAG_W-1:0] m_t2   [DEPTH];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s got=%h need=%h @%0t", nm, act, req, $time);
    end
  endtask

  task automatic idle();
    dispatch_valid = 1'b0;
    cdb_valid      = 1'b0;
    flush          = 1'b0;
  endtask

  task automatic disp(input alu_ops op, input logic [TAG_W-1:0] t,
                      input bit r1, input logic [31:0] v1, input logic [TAG_W-1:0] t1,
                      input bit r2, input logic [31:0] v2, input logic [TAG_W-1:0] t2);
    dispatch_valid    = 1'b1;
    dispatch_aluop    = op;
    dispatch_dest_tag = t;
    dispatch_src1_rdy = r1;
    dispatch_src1_val = v1;
    dispatch_src1_tag = t1;
    dispatch_src2_rdy = r2;
    dispatch_src2_val = v2;
    dispatch_src2_tag = t2;
  endtask

  task automatic cdb(input logic [TAG_W-1:0] t, input logic [31:0] d);
    cdb_valid = 1'b1;
    cdb_tag   = t;
    cdb_data  = d;
  endtask

  // Inputs are set at the falling edge; check this cycle, advance the model, move to next falling edge.
  task automatic step();
    int cand;
    int fr;
    exp_t e;
    #1;
    cand = -1;
    fr   = -1;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (m_busy[i] && m_r1[i] && m_r2[i]) cand = i;
      if (!m_busy[i]) fr = i;
    end
    check("dispatch_ready", 32'(dispatch_ready), 32'(fr >= 0));
    check("issue_valid", 32'(issue_valid), 32'(cand >= 0));
    if (cand < 0)
      check("idle_outputs_zero", issue_a | issue_b | 32'(issue_tag) | 32'(issue_aluop), 32'd0);
    if (cand >= 0 && issue_ready) begin
      e.op  = m_op[cand];
      e.a   = m_v1[cand];
      e.b   = m_v2[cand];
      e.tag = m_tag[cand];
      exp_q.push_back(e);
    end
    if (cdb_valid) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (m_busy[i] && !m_r1[i] && m_t1[i] == cdb_tag) begin m_r1[i] = 1; m_v1[i] = cdb_data; end
        if (m_busy[i] && !m_r2[i] && m_t2[i] == cdb_tag) begin m_r2[i] = 1; m_v2[i] = cdb_data; end
      end
    end
    if (cand >= 0 && issue_ready) m_busy[cand] = 0;
    if (dispatch_valid && fr >= 0 && !flush) begin
      m_busy[fr] = 1;
      m_op[fr]   = dispatch_aluop;
      m_tag[fr]  = dispatch_dest_tag;
      m_t1[fr]   = dispatch_src1_tag;
      m_t2[fr]   = dispatch_src2_tag;
      m_r1[fr]   = dispatch_src1_rdy || (cdb_valid && dispatch_src1_tag == cdb_tag);
      m_r2[fr]   = dispatch_src2_rdy || (cdb_valid && dispatch_src2_tag == cdb_tag);
      m_v1[fr]   = dispatch_src1_rdy ? dispatch_src1_val : cdb_data;
      m_v2[fr]   = dispatch_src2_rdy ? dispatch_src2_val : cdb_data;
    end
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) m_busy[i] = 0;
    end
    @(negedge clk);
    idle();
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_busy[i] = 0;
    exp_q.delete();
  endtask

  // Monitor: compares every accepted issue against the oldest predicted packet.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (rst_n === 1'b1 && issue_valid && issue_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL issue_unexpected got op=%0d tag=%0d a=%h b=%h need no issue",
                   issue_aluop, issue_tag, issue_a, issue_b);
        end else begin
          e = exp_q.pop_front();
          if (issue_aluop !== e.op || issue_tag !== e.tag || issue_a !== e.a || issue_b !== e.b) begin
            bad++;
            $display("FAIL issue_pkt got op=%0d tag=%0d a=%h b=%h need op=%0d tag=%0d a=%h b=%h",
                     issue_aluop, issue_tag, issue_a, issue_b, e.op, e.tag, e.a, e.b);
          end
        end
      end
    end
  end

  initial begin
    rst_n       = 1'b0;
    issue_ready = 1'b0;
    idle();
    disp(alu_add, 0, 0, 0, 0, 0, 0, 0);
    dispatch_valid = 1'b0;
    cdb_tag  = '0;
    cdb_data = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_dispatch_ready", 32'(dispatch_ready), 32'd1);
    check("rst_issue_valid", 32'(issue_valid), 32'd0);
    check("rst_issue_outputs", issue_a | issue_b | 32'(issue_tag) | 32'(issue_aluop), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Both-ready op issues the next cycle.
    issue_ready = 1'b1;
    disp(alu_add, 3'd1, 1, 32'd5, 0, 1, 32'd7, 0); step();
    step(); step();

    // Pending src1 woken by a later broadcast.
    disp(alu_sub, 3'd4, 0, 0, 3'd3, 1, 32'd1, 0); step();
    step(); step();
    cdb(3'd3, 32'h1234); step();
    step();

    // Dispatch/CDB bypass on src2.
    disp(alu_or, 3'd5, 1, 32'd1, 0, 0, 0, 3'd2); cdb(3'd2, 32'd9); step();
    step();

    // Fill, then release one issue.
    issue_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      disp(alu_xor, TAG_W'(i), 1, 32'(100 + i), 0, 1, 32'(200 + i), 0); step();
    end
    step();
    issue_ready = 1'b1; step();
    issue_ready = 1'b0; step();
    issue_ready = 1'b1; repeat (4) step();

    // Entries 1 and 3 ready, 0 and 2 pending: issue order 1 then 3.
    issue_ready = 1'b0;
    disp(alu_and, 3'd0, 0, 0, 3'd6, 1, 32'd1, 0); step();
    disp(alu_and, 3'd1, 1, 32'd11, 0, 1, 32'd12, 0); step();
    disp(alu_and, 3'd2, 1, 32'd2, 0, 0, 0, 3'd6); step();
    disp(alu_and, 3'd3, 1, 32'd31, 0, 1, 32'd32, 0); step();
    issue_ready = 1'b1; step(); step();
    cdb(3'd6, 32'hABCD); step();
    repeat (3) step();

    // Flush with a concurrent dispatch and issue.
    issue_ready = 1'b0;
    disp(alu_sll, 3'd1, 1, 32'd1, 0, 1, 32'd2, 0); step();
    disp(alu_srl, 3'd2, 0, 0, 3'd7, 1, 32'd3, 0); step();
    disp(alu_sra, 3'd3, 1, 32'd4, 0, 1, 32'd5, 0); step();
    issue_ready = 1'b1;
    disp(alu_add, 3'd4, 1, 32'd6, 0, 1, 32'd7, 0); flush = 1'b1; step();
    repeat (3) step();

    // Random traffic.
    for (int c = 0; c < 1500; c++) begin
      issue_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 9) < 6)
        disp(alu_ops'($urandom_range(0, 7)), TAG_W'($urandom),
             $urandom_range(0, 1) == 1, $urandom, TAG_W'($urandom),
             $urandom_range(0, 1) == 1, $urandom, TAG_W'($urandom));
      if ($urandom_range(0, 9) < 5) cdb(TAG_W'($urandom), $urandom);
      flush = ($urandom_range(0, 99) < 3);
      step();
    end

    // Asynchronous reset mid-operation clears outputs before any edge.
    issue_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      disp(alu_add, TAG_W'(i), 1, 32'(i), 0, 1, 32'(i), 0); step();
    end
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_issue_valid", 32'(issue_valid), 32'd0);
    check("async_rst_dispatch_ready", 32'(dispatch_ready), 32'd1);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    issue_ready = 1'b1;
    disp(alu_or, 3'd6, 1, 32'h55, 0, 1, 32'hAA, 0); step();
    step();

    // Drain anything still waiting on a tag.
    issue_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      cdb(TAG_W'(i), $urandom);
      step();
    end
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
